// File: rtl/mesh_link_port_pkg.sv
// Shared mesh types: the link word and the mesh direction enum used by the
// port and, later, by the router.
package mesh_link_port_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W
    } mesh_dir_t;
endpackage

// File: rtl/link_fifo.sv
// Power-of-two FIFO with a registered occupancy count. The full/empty flags
// come from the count register, so neither one has a combinational path from
// any input.
module link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ren,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = CNT_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = wen && !full;
    assign do_pop    = ren && !empty;
    assign overflow  = wen && full;
    assign underflow = ren && empty;
    assign rdata     = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mesh_link_port.sv
// Tile-side endpoint of one mesh link direction: TX FIFO toward the link,
// RX FIFO toward the core, sticky error flags.
module mesh_link_port
    import mesh_link_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [WORD_W-1:0]      core_tx_data,
    input  logic                   core_tx_wen,
    output logic                   core_tx_full,
    output logic [WORD_W-1:0]      core_rx_data,
    input  logic                   core_rx_ren,
    output logic                   core_rx_empty,
    output logic [WORD_W-1:0]      link_send_data,
    output logic                   link_send_ready,
    input  logic                   link_send_done,
    input  logic [WORD_W-1:0]      link_recv_data,
    input  logic                   link_recv_valid,
    output logic                   link_recv_ready,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   err_overflow,
    output logic                   err_underflow
);
    logic tx_empty;
    logic tx_overflow;
    logic tx_underflow_unused;
    logic rx_full;
    logic rx_overflow;
    logic rx_underflow;

    link_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_tx_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .wen       (core_tx_wen),
        .wdata     (core_tx_data),
        .ren       (link_send_done),
        .rdata     (link_send_data),
        .full      (core_tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .overflow  (tx_overflow),
        .underflow (tx_underflow_unused)
    );

    link_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_rx_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .wen       (link_recv_valid),
        .wdata     (link_recv_data),
        .ren       (core_rx_ren),
        .rdata     (core_rx_data),
        .full      (rx_full),
        .empty     (core_rx_empty),
        .count     (rx_count),
        .overflow  (rx_overflow),
        .underflow (rx_underflow)
    );

    // Both link handshakes derive from count registers only; the link
    // interface ANDs them across tiles.
    assign link_send_ready = !tx_empty;
    assign link_recv_ready = !rx_full;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (tx_overflow || rx_overflow) begin
                err_overflow <= 1'b1;
            end
            if (rx_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end
endmodule
